// File: rtl/uart_rx_ctrl_gen.sv
// UART receive controller: oversampled bit timing, 3-sample majority vote, frame FSM,
// LSB-first deserialiser, parity/stop checking and break detection.
module uart_rx_ctrl_gen #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned PRESCALE_MAX = 32,
  parameter int unsigned PRESC_WIDTH  = $clog2(PRESCALE_MAX) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   RX_IN,
  input  logic [PRESC_WIDTH-1:0] prescale,
  input  logic                   par_en,
  input  logic                   par_typ,
  input  logic                   two_stop,
  output logic [DATA_WIDTH-1:0]  P_DATA,
  output logic                   data_valid,
  output logic                   par_err,
  output logic                   stop_err,
  output logic                   break_det,
  output logic                   busy
);

  localparam int unsigned PW = PRESC_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned BW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   edge_q, edge_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            par_en_q, par_en_d, par_typ_q, par_typ_d, two_stop_q, two_stop_d;
  logic            samp0_q, samp0_d, samp1_q, samp1_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic            par_bit_q, par_bit_d, par_bad_q, par_bad_d;
  logic            stop_bad_q, stop_bad_d, brk_cand_q, brk_cand_d;
  logic [DW-1:0]   pdata_q, pdata_d;
  logic            dv_q, dv_d, pe_q, pe_d, se_q, se_d, brk_q, brk_d, busy_q, busy_d;

  logic [PW-1:0]   presc_even_c, presc_eff_c, half_c;
  logic            at_last_c, decide_c, dec_c, done_c, brk_c, stop_bad_c;

  // Bit 0 of prescale is dropped; ratios below 4 are clamped to 4
  assign presc_even_c = prescale & ~PW'(1);
  assign presc_eff_c  = (presc_even_c < PW'(4)) ? PW'(4) : presc_even_c;
  assign half_c       = presc_q >> 1;
  assign at_last_c    = (edge_q == presc_q - PW'(1));
  assign decide_c     = (edge_q == half_c + PW'(1));
  assign dec_c        = (samp0_q & samp1_q) | (samp0_q & RX_IN) | (samp1_q & RX_IN);

  always_comb begin
    state_d    = state_q;
    edge_d     = edge_q;
    bit_d      = bit_q;
    presc_d    = presc_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    two_stop_d = two_stop_q;
    samp0_d    = samp0_q;
    samp1_d    = samp1_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    par_bad_d  = par_bad_q;
    stop_bad_d = stop_bad_q;
    brk_cand_d = brk_cand_q;
    pdata_d    = pdata_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;
    brk_d      = 1'b0;
    done_c     = 1'b0;
    brk_c      = 1'b0;
    stop_bad_c = stop_bad_q;

    if (state_q != IDLE && state_q != BRK_WAIT) begin
      edge_d = at_last_c ? '0 : edge_q + PW'(1);
      if (edge_q == half_c - PW'(1)) samp0_d = RX_IN;
      if (edge_q == half_c)          samp1_d = RX_IN;
    end

    case (state_q)
      IDLE: begin
        edge_d = '0;
        bit_d  = '0;
        if (!RX_IN) begin
          state_d    = START;
          presc_d    = presc_eff_c;
          par_en_d   = par_en;
          par_typ_d  = par_typ;
          two_stop_d = two_stop;
          par_bit_d  = 1'b0;
          par_bad_d  = 1'b0;
          stop_bad_d = 1'b0;
          brk_cand_d = 1'b0;
        end
      end
      START: begin
        if (decide_c && dec_c) begin
          state_d    = IDLE;
          edge_d     = '0;
          par_bad_d  = 1'b0;
          stop_bad_d = 1'b0;
          brk_cand_d = 1'b0;
        end else if (at_last_c) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (decide_c) shift_d = {dec_c, shift_q[DW-1:1]};
        if (at_last_c) begin
          if (bit_q == BW'(DW - 1)) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP1;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (decide_c) begin
          par_bit_d = dec_c;
          par_bad_d = dec_c != ((^shift_q) ^ par_typ_q);
        end
        if (at_last_c) state_d = STOP1;
      end
      STOP1: begin
        if (decide_c) begin
          stop_bad_c = !dec_c;
          stop_bad_d = !dec_c;
          brk_c      = (shift_q == '0) && !par_bit_q && !dec_c;
          brk_cand_d = brk_c;
          done_c     = !two_stop_q;
        end
        if (at_last_c && two_stop_q) state_d = STOP2;
      end
      STOP2: begin
        if (decide_c) begin
          stop_bad_c = stop_bad_q | !dec_c;
          brk_c      = brk_cand_q;
          done_c     = 1'b1;
        end
      end
      BRK_WAIT: begin
        edge_d = '0;
        if (RX_IN) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Frame ends mid stop bit so a following start edge is not missed
    if (done_c) begin
      edge_d = '0;
      bit_d  = '0;
      if (brk_c) begin
        brk_d   = 1'b1;
        state_d = BRK_WAIT;
      end else begin
        state_d = IDLE;
        se_d    = stop_bad_c;
        pe_d    = par_bad_q;
        if (!stop_bad_c && !par_bad_q) begin
          dv_d    = 1'b1;
          pdata_d = shift_q;
        end
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      edge_q     <= '0;
      bit_q      <= '0;
      presc_q    <= PW'(4);
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      two_stop_q <= 1'b0;
      samp0_q    <= 1'b1;
      samp1_q    <= 1'b1;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      par_bad_q  <= 1'b0;
      stop_bad_q <= 1'b0;
      brk_cand_q <= 1'b0;
      pdata_q    <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
      brk_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      presc_q    <= presc_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      two_stop_q <= two_stop_d;
      samp0_q    <= samp0_d;
      samp1_q    <= samp1_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      par_bad_q  <= par_bad_d;
      stop_bad_q <= stop_bad_d;
      brk_cand_q <= brk_cand_d;
      pdata_q    <= pdata_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
      brk_q      <= brk_d;
      busy_q     <= busy_d;
    end
  end

  assign P_DATA     = pdata_q;
  assign data_valid = dv_q;
  assign par_err    = pe_q;
  assign stop_err   = se_q;
  assign break_det  = brk_q;
  assign busy       = busy_q;

endmodule

// File: doc/uart_rx_ctrl_gen.md
Name: uart_rx_ctrl_gen

Overview:
Parametrised next-generation UART receive controller. It integrates bit timing, 3-sample majority voting, the frame FSM, deserialisation and error checking in one block. It adds configurable data width, runtime prescale, odd/even parity, 1 or 2 stop bits and break detection. It sits between the RX pin synchroniser and the RX-side data synchroniser/CDC stage.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
PRESCALE_MAX, 32, largest supported oversampling ratio.
PRESC_WIDTH, $clog2(PRESCALE_MAX)+1, width of the prescale port.

Ports:
clk  input  1  system clock (RX oversampling clock)
rst  input  1  synchronous reset, active-high
RX_IN  input  1  serial line, already synchronised; idle high
prescale  input  PRESC_WIDTH  oversampling ratio; bit 0 ignored; values below 4 treated as 4
par_en  input  1  parity bit present
par_typ  input  1  0 = even, 1 = odd
two_stop  input  1  1 = two stop bits
P_DATA  output  DATA_WIDTH  last error-free received word
data_valid  output  1  one-cycle pulse: P_DATA updated
par_err  output  1  one-cycle pulse: parity mismatch in the completed frame
stop_err  output  1  one-cycle pulse: a stop bit sampled low
break_det  output  1  one-cycle pulse: break condition detected
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: synchronous, active-high, wins over all other activity, including mid-frame. State returns to IDLE. All counters clear. P_DATA = 0. All pulse outputs and busy = 0.
- Configuration latch: prescale, par_en, par_typ and two_stop are captured on the cycle IDLE sees RX_IN = 0. Changes mid-frame are ignored.
- Start detection: the cycle IDLE sees RX_IN = 0 is cycle 0. On cycle 1 the FSM is in START, edge_cnt = 0, bit_cnt = 0.
- Bit timing:
  - edge_cnt counts 0..P-1, where P is the latched prescale. It wraps to 0 and bit_cnt increments at P-1.
  - With H = P/2, samples are taken at edge_cnt = H-1, H and H+1.
  - The bit decision is the 2-of-3 majority, formed on the cycle edge_cnt = H+1.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT.
  - IDLE -> START when RX_IN = 0.
  - START, on its decision:
    - decision 1 (glitch): go to IDLE silently, no pulses.
    - decision 0: continue to DATA at the bit boundary.
  - DATA: shift the decision into the shift register LSB-first. After DATA_WIDTH bits go to PARITY if par_en=1, else to STOP1.
  - PARITY: compare the decision against the XOR of the data bits, inverted when par_typ=1. Latch the mismatch internally. Go to STOP1.
  - STOP1, on its decision:
    - two_stop=1: go to STOP2.
    - two_stop=0: the frame completes here.
  - STOP2, on its decision: the frame completes here.
  - Frame completion: go straight to IDLE on the decision cycle (mid stop bit) so back-to-back frames are captured. Exception: a break goes to BRK_WAIT.
  - BRK_WAIT -> IDLE on the first cycle RX_IN = 1.
- Completion outputs, all registered, asserted for exactly one cycle, on the cycle after the final stop decision:
  - stop_err = 1 if any stop decision is 0 and the frame is not a break.
  - par_err = 1 if the latched parity mismatch is set.
  - break_det = 1 if all data bits are 0, the parity bit (if present) is 0, and stop1 is 0. break_det suppresses stop_err and par_err.
  - data_valid = 1 and P_DATA = shift register only if no error and no break. Otherwise P_DATA holds its previous value.
- Latency: data_valid is asserted (F-1)*P + P/2 + 3 cycles after cycle 0, where F = 1 + DATA_WIDTH + par_en + 1 + two_stop.
- Any mismatch of a START decision aborts the frame and clears the internal error flags.

Test Plan:
- Reset 3 cycles, then RX_IN idle high, 50 cycles -> busy = 0, P_DATA = 0x00, no pulses.
- DATA_WIDTH=8, prescale=8, no parity, one stop, frame 0xA5 -> data_valid pulse at cycle 79, P_DATA = 0xA5, par_err = stop_err = 0.
- prescale=16, par_en=1, par_typ=1, data 0x3C sent with parity bit 0 -> par_err pulse, data_valid = 0, P_DATA unchanged. Repeat with parity 1 -> data_valid, P_DATA = 0x3C.
- prescale=8, RX_IN low for 2 cycles only -> FSM returns to IDLE after the START decision, no pulses. Two-stop frame 0x81 with stop2 = 0 -> stop_err pulse, no data_valid.
- Line held low for 3 full frame times, then released -> single break_det pulse, busy high until RX_IN returns to 1, then IDLE. Back-to-back frames 0x11, 0x22 with no idle gap -> two data_valid pulses, P_DATA = 0x11 then 0x22.
- Assert rst in the middle of DATA bit 4 -> next cycle IDLE, busy = 0, P_DATA = 0. A following clean frame 0x5A is received correctly.
